skid_buffer: RTL and testbench

- Two-entry valid/ready register slice; the consumer-facing read end of a pipeline stage register.
- Accepts a word from an upstream producer and holds it until a downstream consumer takes it.
- Full throughput: 1 word/clk, with registered data output and backpressure.
- Sits between streaming stages (pixel/window paths) in modules/common wherever the downstream stage can stall.

---
 rtl/skid_buffer.sv | 114 +++++++++++
 tb/tb_skid_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice: main register drives out_data, skid register absorbs
// the word that arrives in the cycle the consumer stalls. Optional stall counter: SKID_BUFFER_STALL_CNT_EN.

module skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SKID_BUFFER_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b01,
        StFull  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_xfer;
    logic             out_xfer;

    // in_ready depends on state and rst only, so out_ready never reaches it combinationally.
    assign in_ready  = (state_q != StFull) && !rst;
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        skid_d  = in_data;
                        state_d = StFull;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = StBusy;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef SKID_BUFFER_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: queue scoreboard plus directed reset, streaming,
// backpressure, flush and (with SKID_BUFFER_STALL_CNT_EN) stall counter checks.

module tb_skid_buffer;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef SKID_BUFFER_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    skid_buffer #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef SKID_BUFFER_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard sampled mid-cycle: models the effect of the coming rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
            check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
            if (out_valid && out_ready && exp_q.size() > 0) begin
                check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        check("send_accept", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        in_data  = 'x;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 'x;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            tick();
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            check("stream_out_data", {24'd0, out_data}, i);
        end
        in_valid = 1'b0;
        in_data  = 'x;
        tick();
        tick();

        // Backpressure: fill, offer a third word, then release.
        out_ready = 1'b0;
        send(8'hA1);
        send(8'hA2);
        in_valid = 1'b1;
        in_data  = 8'hA3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_data", {24'd0, out_data}, 32'hA1);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_second", {24'd0, out_data}, 32'hA2);
        send(8'hA3);
        check("bp_third", {24'd0, out_data}, 32'hA3);
        tick();
        tick();

        // Flush in FULL together with an incoming word.
        out_ready = 1'b0;
        send(8'hB1);
        send(8'hB2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hB3;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 'x;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        send(8'hC4);
        check("flush_next_word", {24'd0, out_data}, 32'hC4);
        tick();

        // Reset asserted mid-cycle with a word held.
        out_ready = 1'b0;
        send(8'h5A);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_data", {24'd0, out_data}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_rst_in_ready_after", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid_after", {31'd0, out_valid}, 32'd0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = in_valid ? WIDTH'($urandom) : 'x;
            tick();
        end
        in_valid  = 1'b0;
        in_data   = 'x;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("drain_empty", exp_q.size(), 32'd0);

`ifdef SKID_BUFFER_STALL_CNT_EN
        out_ready = 1'b0;
        send(8'h77);
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        check("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("stall_flush", {16'd0, stall_cnt}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
